control_unit_pipe: RTL and testbench

Pipelined RV32I control unit for the five-stage core. Decodes the 32-bit instruction in ID and carries the resulting control bundle through ID/EX, EX/MEM and MEM/WB registers, so each datapath stage reads its own stage-local controls. Generalises the single-cycle control path:
- adds JAL/JALR/LUI/AUIPC and the full ALU op set;
- adds stall/flush handling, an illegal-instruction flag and a saturating illegal-instruction counter.

---
 rtl/cu_pkg.sv | 94 +++++++++
 rtl/cu_decode.sv | 130 +++++++++++++
 rtl/control_unit_pipe.sv | 104 ++++++++++
 tb/tb_control_unit_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared decode constants and control payload types for the pipelined control unit.
// Contents: opcode and ALU code enums, ImmSrc/ResultSrc encodings, the
// ID-stage control bundle and the trimmed EX/MEM and MEM/WB payloads,
// plus a helper that maps funct3 to the base (funct7=0) ALU operation.
package cu_pkg;

  localparam int unsigned ALU_CODE_W = 4;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [ALU_CODE_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASSB  = 4'd10,
    ALU_MUL    = 4'd11,
    ALU_MULH   = 4'd12,
    ALU_MULHSU = 4'd13,
    ALU_MULHU  = 4'd14,
    ALU_DIV    = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  typedef struct packed {
    logic     ALUSrcA;
    logic     ALUSrcB;
    alu_op_e  ALUControl;
    logic     Branch;
    logic     Jump;
    logic     JumpReg;
    logic     MemWrite;
    logic     RegWrite;
    res_src_e ResultSrc;
    logic [2:0] funct3;
    logic     illegal;
  } ctrl_bundle_t;

  typedef struct packed {
    logic     MemWrite;
    logic     RegWrite;
    res_src_e ResultSrc;
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic     RegWrite;
    res_src_e ResultSrc;
  } wb_ctrl_t;

  // funct3 -> ALU op for the funct7=0000000 encodings shared by R and I types.
  function automatic alu_op_e base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational RV32I instruction decoder: instr -> control bundle.
// Ports: instr (32b ID instruction), id_valid (0 = bubble),
//        ctrl_c (decoded bundle), imm_src_c (immediate select).
// Optional build macro CU_MULDIV_EN enables the M-extension encodings.
module cu_decode
  import cu_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4
) (
  input  logic [31:0]  instr,
  input  logic         id_valid,
  output ctrl_bundle_t ctrl_c,
  output imm_src_e     imm_src_c
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       unused_fields;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register specifiers are datapath concerns, not control.
  assign unused_fields = ^{instr[24:15], instr[11:7]};

`ifndef CU_MULDIV_EN
  logic unused_alu_w;
  assign unused_alu_w = (ALU_CTRL_W >= 5);
`endif

  // Class decode; illegal or invalid instructions collapse to a bubble.
  always_comb begin
    ctrl_c        = '0;
    ctrl_c.funct3 = funct3;
    imm_src_c     = IMM_I;
    legal         = 1'b1;

    case (opcode)
      OP_R: begin
        ctrl_c.RegWrite = 1'b1;
        case (funct7)
          7'b0000000: ctrl_c.ALUControl = base_alu(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)      ctrl_c.ALUControl = ALU_SUB;
            else if (funct3 == 3'b101) ctrl_c.ALUControl = ALU_SRA;
            else                       legal = 1'b0;
          end
`ifdef CU_MULDIV_EN
          7'b0000001: begin
            case (funct3)
              3'b000:  ctrl_c.ALUControl = ALU_MUL;
              3'b001:  ctrl_c.ALUControl = ALU_MULH;
              3'b010:  ctrl_c.ALUControl = ALU_MULHSU;
              3'b011:  ctrl_c.ALUControl = ALU_MULHU;
              default: begin
                // Divide/remainder share one code, only reachable with a wide ALU field.
                if (ALU_CTRL_W >= 5) ctrl_c.ALUControl = ALU_DIV;
                else                 legal = 1'b0;
              end
            endcase
          end
`endif
          default: legal = 1'b0;
        endcase
      end
      OP_I: begin
        ctrl_c.RegWrite = 1'b1;
        ctrl_c.ALUSrcB  = 1'b1;
        // Only the right-shift immediate uses funct7[5]; ADDI ignores it.
        if (funct3 == 3'b101 && funct7[5]) ctrl_c.ALUControl = ALU_SRA;
        else                               ctrl_c.ALUControl = base_alu(funct3);
      end
      OP_LOAD: begin
        ctrl_c.RegWrite  = 1'b1;
        ctrl_c.ALUSrcB   = 1'b1;
        ctrl_c.ResultSrc = RES_MEM;
      end
      OP_STORE: begin
        ctrl_c.MemWrite = 1'b1;
        ctrl_c.ALUSrcB  = 1'b1;
        imm_src_c       = IMM_S;
      end
      OP_BRANCH: begin
        ctrl_c.Branch     = 1'b1;
        ctrl_c.ALUControl = ALU_SUB;
        imm_src_c         = IMM_B;
      end
      OP_JAL: begin
        ctrl_c.Jump      = 1'b1;
        ctrl_c.RegWrite  = 1'b1;
        ctrl_c.ALUSrcA   = 1'b1;
        ctrl_c.ALUSrcB   = 1'b1;
        ctrl_c.ResultSrc = RES_PC4;
        imm_src_c        = IMM_J;
      end
      OP_JALR: begin
        ctrl_c.JumpReg   = 1'b1;
        ctrl_c.RegWrite  = 1'b1;
        ctrl_c.ALUSrcB   = 1'b1;
        ctrl_c.ResultSrc = RES_PC4;
      end
      OP_LUI: begin
        ctrl_c.RegWrite   = 1'b1;
        ctrl_c.ALUSrcB    = 1'b1;
        ctrl_c.ALUControl = ALU_PASSB;
        imm_src_c         = IMM_U;
      end
      OP_AUIPC: begin
        ctrl_c.RegWrite = 1'b1;
        ctrl_c.ALUSrcA  = 1'b1;
        ctrl_c.ALUSrcB  = 1'b1;
        imm_src_c       = IMM_U;
      end
      default: legal = 1'b0;
    endcase

    if (!id_valid) begin
      ctrl_c    = '0;
      imm_src_c = IMM_I;
    end else if (!legal) begin
      ctrl_c         = '0;
      ctrl_c.illegal = 1'b1;
      imm_src_c      = IMM_I;
    end
  end

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined RV32I control unit: decodes in ID and carries controls through
// ID/EX, EX/MEM and MEM/WB, plus a saturating illegal-instruction counter.
// Ports: clk, rst (async, active high), instr, id_valid, stall, flush;
//        id_ImmSrc (combinational), ex_* / mem_* / wb_* stage controls,
//        ex_illegal, illegal_count.
// Optional build macro CU_MULDIV_EN (passed through to cu_decode).
module control_unit_pipe
  import cu_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic                  id_valid,
  input  logic                  stall,
  input  logic                  flush,
  output logic [2:0]            id_ImmSrc,
  output logic                  ex_ALUSrcA,
  output logic                  ex_ALUSrcB,
  output logic [ALU_CTRL_W-1:0] ex_ALUControl,
  output logic                  ex_Branch,
  output logic                  ex_Jump,
  output logic                  ex_JumpReg,
  output logic [2:0]            ex_funct3,
  output logic                  mem_MemWrite,
  output logic [2:0]            mem_funct3,
  output logic                  wb_RegWrite,
  output logic [1:0]            wb_ResultSrc,
  output logic                  ex_illegal,
  output logic [CNT_W-1:0]      illegal_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  ctrl_bundle_t     id_ctrl_c;
  imm_src_e         id_imm_c;
  ctrl_bundle_t     idex_q;
  mem_ctrl_t        exmem_q;
  wb_ctrl_t         memwb_q;
  logic [CNT_W-1:0] cnt_q;

  cu_decode #(.ALU_CTRL_W(ALU_CTRL_W)) u_decode (
    .instr     (instr),
    .id_valid  (id_valid),
    .ctrl_c    (id_ctrl_c),
    .imm_src_c (id_imm_c)
  );

  // ID/EX: flush beats stall so a squashed instruction never lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         idex_q <= '0;
    else if (flush)  idex_q <= '0;
    else if (!stall) idex_q <= id_ctrl_c;
  end

  // EX/MEM: holds under stall regardless of flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_q <= '0;
    end else if (!stall) begin
      exmem_q.MemWrite  <= idex_q.MemWrite;
      exmem_q.RegWrite  <= idex_q.RegWrite;
      exmem_q.ResultSrc <= idex_q.ResultSrc;
      exmem_q.funct3    <= idex_q.funct3;
    end
  end

  // MEM/WB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memwb_q <= '0;
    end else if (!stall) begin
      memwb_q.RegWrite  <= exmem_q.RegWrite;
      memwb_q.ResultSrc <= exmem_q.ResultSrc;
    end
  end

  // Counts only illegal instructions that actually land in ID/EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!flush && !stall && id_ctrl_c.illegal && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign id_ImmSrc     = id_imm_c;
  assign ex_ALUSrcA    = idex_q.ALUSrcA;
  assign ex_ALUSrcB    = idex_q.ALUSrcB;
  assign ex_ALUControl = ALU_CTRL_W'(idex_q.ALUControl);
  assign ex_Branch     = idex_q.Branch;
  assign ex_Jump       = idex_q.Jump;
  assign ex_JumpReg    = idex_q.JumpReg;
  assign ex_funct3     = idex_q.funct3;
  assign ex_illegal    = idex_q.illegal;
  assign mem_MemWrite  = exmem_q.MemWrite;
  assign mem_funct3    = exmem_q.funct3;
  assign wb_RegWrite   = memwb_q.RegWrite;
  assign wb_ResultSrc  = memwb_q.ResultSrc;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed self-checking bench for control_unit_pipe (default parameters).
module tb_control_unit_pipe;

  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned CNT_W      = 8;

  localparam logic [31:0] I_ADD  = 32'h00B50533;
  localparam logic [31:0] I_SUB  = 32'h40B50533;
  localparam logic [31:0] I_LW   = 32'h0002A303;
  localparam logic [31:0] I_SW   = 32'h0062A023;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_BEQ  = 32'h00628463;
  localparam logic [31:0] I_LUI  = 32'h123452B7;
  localparam logic [31:0] I_MUL  = 32'h02B50533;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [31:0]           instr = '0;
  logic                  id_valid = 1'b0;
  logic                  stall = 1'b0;
  logic                  flush = 1'b0;
  logic [2:0]            id_ImmSrc;
  logic                  ex_ALUSrcA, ex_ALUSrcB;
  logic [ALU_CTRL_W-1:0] ex_ALUControl;
  logic                  ex_Branch, ex_Jump, ex_JumpReg;
  logic [2:0]            ex_funct3;
  logic                  mem_MemWrite;
  logic [2:0]            mem_funct3;
  logic                  wb_RegWrite;
  logic [1:0]            wb_ResultSrc;
  logic                  ex_illegal;
  logic [CNT_W-1:0]      illegal_count;
  logic [31:0]           all_q;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  control_unit_pipe #(.ALU_CTRL_W(ALU_CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .id_valid(id_valid),
    .stall(stall), .flush(flush), .id_ImmSrc(id_ImmSrc),
    .ex_ALUSrcA(ex_ALUSrcA), .ex_ALUSrcB(ex_ALUSrcB),
    .ex_ALUControl(ex_ALUControl), .ex_Branch(ex_Branch),
    .ex_Jump(ex_Jump), .ex_JumpReg(ex_JumpReg), .ex_funct3(ex_funct3),
    .mem_MemWrite(mem_MemWrite), .mem_funct3(mem_funct3),
    .wb_RegWrite(wb_RegWrite), .wb_ResultSrc(wb_ResultSrc),
    .ex_illegal(ex_illegal), .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  assign all_q = 32'({ex_ALUSrcA, ex_ALUSrcB, ex_ALUControl, ex_Branch, ex_Jump,
                      ex_JumpReg, ex_funct3, mem_MemWrite, mem_funct3,
                      wb_RegWrite, wb_ResultSrc, ex_illegal, illegal_count});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
    instr = i; id_valid = v; stall = s; flush = f;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("rst_all", all_q, 32'd0);
    tick();
    rst = 1'b0;

    // add then sub, then bubbles to drain
    drive(I_ADD, 1, 0, 0); #1;
    check("add_imm", 32'(id_ImmSrc), 32'd0);
    tick();
    check("add_alu", 32'(ex_ALUControl), 32'd0);
    check("add_ill", 32'(ex_illegal), 32'd0);
    drive(I_SUB, 1, 0, 0);
    tick();
    check("sub_alu", 32'(ex_ALUControl), 32'd1);
    check("sub_srcb", 32'(ex_ALUSrcB), 32'd0);
    drive(32'd0, 0, 0, 0);
    tick();
    check("add_wb_rw", 32'(wb_RegWrite), 32'd1);
    check("add_wb_rs", 32'(wb_ResultSrc), 32'd0);
    check("bub_alu", 32'(ex_ALUControl), 32'd0);
    tick();
    check("sub_wb_rw", 32'(wb_RegWrite), 32'd1);
    check("sub_wb_rs", 32'(wb_ResultSrc), 32'd0);
    tick();
    check("bub_wb_rw", 32'(wb_RegWrite), 32'd0);

    // lw held by a 2-cycle stall
    drive(I_LW, 1, 0, 0);
    tick();
    check("lw_srcb", 32'(ex_ALUSrcB), 32'd1);
    check("lw_f3", 32'(ex_funct3), 32'd2);
    drive(32'd0, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("lw_hold_srcb", 32'(ex_ALUSrcB), 32'd1);
      check("lw_hold_f3", 32'(ex_funct3), 32'd2);
      check("lw_hold_mem", 32'(mem_funct3), 32'd0);
    end
    drive(32'd0, 0, 0, 0);
    tick();
    check("lw_mem_f3", 32'(mem_funct3), 32'd2);
    check("lw_ex_gone", 32'(ex_funct3), 32'd0);
    tick();
    check("lw_wb_rs", 32'(wb_ResultSrc), 32'd1);
    check("lw_wb_rw", 32'(wb_RegWrite), 32'd1);

    // sw, lw, add in flight, then jal with flush+stall together
    drive(I_SW, 1, 0, 0); #1;
    check("sw_imm", 32'(id_ImmSrc), 32'd1);
    tick();
    drive(I_LW, 1, 0, 0);
    tick();
    check("sw_mem_we", 32'(mem_MemWrite), 32'd1);
    check("sw_mem_f3", 32'(mem_funct3), 32'd2);
    drive(I_ADD, 1, 0, 0);
    tick();
    check("pre_mem_f3", 32'(mem_funct3), 32'd2);
    check("pre_wb_rw", 32'(wb_RegWrite), 32'd0);
    drive(I_JAL, 1, 1, 1); #1;
    check("jal_imm", 32'(id_ImmSrc), 32'd3);
    tick();
    check("fs_ex_jump", 32'(ex_Jump), 32'd0);
    check("fs_ex_srca", 32'(ex_ALUSrcA), 32'd0);
    check("fs_mem_f3", 32'(mem_funct3), 32'd2);
    check("fs_wb_rw", 32'(wb_RegWrite), 32'd0);
    check("fs_wb_rs", 32'(wb_ResultSrc), 32'd0);
    drive(I_JAL, 1, 0, 0);
    tick();
    check("jal_jump", 32'(ex_Jump), 32'd1);
    check("jal_srca", 32'(ex_ALUSrcA), 32'd1);
    check("jal_srcb", 32'(ex_ALUSrcB), 32'd1);
    check("jal_alu", 32'(ex_ALUControl), 32'd0);
    check("jal_mem_f3", 32'(mem_funct3), 32'd0);
    check("jal_wb_lw", 32'(wb_ResultSrc), 32'd1);
    drive(I_BEQ, 1, 0, 0); #1;
    check("beq_imm", 32'(id_ImmSrc), 32'd2);
    tick();
    check("beq_br", 32'(ex_Branch), 32'd1);
    check("beq_alu", 32'(ex_ALUControl), 32'd1);
    check("beq_jump", 32'(ex_Jump), 32'd0);
    check("beq_mem_we", 32'(mem_MemWrite), 32'd0);
    drive(I_JAL, 0, 0, 0); #1;
    check("inv_imm", 32'(id_ImmSrc), 32'd0);
    tick();
    check("jal_wb_rs", 32'(wb_ResultSrc), 32'd2);
    check("jal_wb_rw", 32'(wb_RegWrite), 32'd1);
    check("inv_br", 32'(ex_Branch), 32'd0);

    // mul: legal only with the M extension build
    drive(I_MUL, 1, 0, 0);
    tick();
`ifdef CU_MULDIV_EN
    check("mul_alu", 32'(ex_ALUControl), 32'd11);
    check("mul_ill", 32'(ex_illegal), 32'd0);
`else
    check("mul_ill", 32'(ex_illegal), 32'd1);
    exp_cnt++;
`endif
    check("mul_cnt", 32'(illegal_count), 32'(exp_cnt));

    // Illegal: stall and flush do not count
    drive(I_BAD, 1, 0, 0); #1;
    check("bad_imm", 32'(id_ImmSrc), 32'd0);
    tick();
    exp_cnt++;
    check("bad_cnt1", 32'(illegal_count), 32'(exp_cnt));
    drive(I_BAD, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bad_stall_cnt", 32'(illegal_count), 32'(exp_cnt));
      check("bad_stall_ill", 32'(ex_illegal), 32'd1);
    end
    drive(I_BAD, 1, 0, 1);
    tick();
    check("bad_flush_ill", 32'(ex_illegal), 32'd0);
    check("bad_flush_cnt", 32'(illegal_count), 32'(exp_cnt));

    // 300 illegal instructions: counter saturates at 255
    drive(I_BAD, 1, 0, 0);
    for (int k = 0; k < 300; k++) begin
      tick();
      if (exp_cnt < 255) exp_cnt++;
      check("sat_ill", 32'(ex_illegal), 32'd1);
      check("sat_cnt", 32'(illegal_count), 32'(exp_cnt));
    end
    check("sat_en", 32'({ex_Branch, ex_Jump, ex_JumpReg, ex_ALUSrcA, ex_ALUSrcB}), 32'd0);
    check("sat_mem_we", 32'(mem_MemWrite), 32'd0);
    check("sat_wb_rw", 32'(wb_RegWrite), 32'd0);
    check("sat_final", 32'(illegal_count), 32'd255);

    // Mid-stream asynchronous reset with bundles in flight
    drive(I_LW, 1, 0, 0);
    tick();
    drive(I_ADD, 1, 0, 0);
    tick();
    drive(I_SW, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_all", all_q, 32'd0);
    tick();
    check("mrst_hold", all_q, 32'd0);
    drive(I_LUI, 1, 0, 0);
    rst = 1'b0;
    tick();
    check("post_lui_alu", 32'(ex_ALUControl), 32'd10);
    check("post_wb_rw", 32'(wb_RegWrite), 32'd0);
    check("post_mem_we", 32'(mem_MemWrite), 32'd0);
    check("post_cnt", 32'(illegal_count), 32'd0);
    drive(32'd0, 0, 0, 0);
    tick();
    tick();
    check("lui_wb_rw", 32'(wb_RegWrite), 32'd1);
    check("lui_wb_rs", 32'(wb_ResultSrc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
